// File: rtl/hex_bcd_display_driver.sv
// Converts the PIO control word into four active-low seven-segment digits.
// Hex or decimal display (sequential double-dabble), with leading-zero blanking and blinking.
module hex_bcd_display_driver #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] value_in,
  output logic [6:0]  hex0_n,
  output logic [6:0]  hex1_n,
  output logic [6:0]  hex2_n,
  output logic [6:0]  hex3_n,
  output logic        busy,
  output logic        overflow
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, ENCODE = 2'd2} state_t;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  4'hF: s = 7'b0001110;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
  function automatic logic [19:0] add3(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      else                     r[i*4 +: 4] = b[i*4 +: 4];
    end
    return r;
  endfunction

  state_t      state_r, state_s;
  logic [18:0] in_r, last_r, last_s;
  logic        pending_r, pending_s;
  logic        mode_r, mode_s, blank_r, blank_s, blink_r, blink_s;
  logic [15:0] bin_r, bin_s;
  logic [19:0] bcd_r, bcd_s, adj_s;
  logic [35:0] shift_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [6:0]  seg0_r, seg1_r, seg2_r, seg3_r, seg0_s, seg1_s, seg2_s, seg3_s;
  logic        overflow_r, overflow_s, busy_r, blink_on_r, blink_on_s;
  logic [15:0] digits_s;
  logic        ovf_calc_s, z3_s, z2_s, z1_s, start_s, mask_s;
  logic [CW-1:0] div_r;
  logic        phase_r;
  logic        unused_bits_s;

  assign unused_bits_s = ^value_in[31:19];

  // Input capture register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) in_r <= 19'd0;
    else          in_r <= value_in[18:0];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Next-state and datapath next values.
  always_comb begin
    start_s    = pending_r || (in_r != last_r);
    adj_s      = add3(bcd_r);
    shift_s    = {adj_s[18:0], bin_r, 1'b0};
    digits_s   = mode_r ? bcd_r[15:0] : bin_r;
    ovf_calc_s = mode_r && (bcd_r[19:16] != 4'd0);
    z3_s       = (digits_s[15:12] == 4'd0);
    z2_s       = z3_s && (digits_s[11:8] == 4'd0);
    z1_s       = z2_s && (digits_s[7:4] == 4'd0);
    state_s    = state_r;
    last_s     = last_r;
    pending_s  = pending_r;
    mode_s     = mode_r;
    blank_s    = blank_r;
    blink_s    = blink_r;
    bin_s      = bin_r;
    bcd_s      = bcd_r;
    cnt_s      = cnt_r;
    seg0_s     = seg0_r;
    seg1_s     = seg1_r;
    seg2_s     = seg2_r;
    seg3_s     = seg3_r;
    overflow_s = overflow_r;
    blink_on_s = blink_on_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          last_s    = in_r;
          pending_s = 1'b0;
          mode_s    = in_r[16];
          blank_s   = in_r[17];
          blink_s   = in_r[18];
          bin_s     = in_r[15:0];
          bcd_s     = 20'h0_0000;
          cnt_s     = 4'd0;
          state_s   = in_r[16] ? SHIFT : ENCODE;
        end else begin
          state_s   = IDLE;
        end
      end
      SHIFT: begin
        bcd_s = shift_s[35:16];
        bin_s = shift_s[15:0];
        cnt_s = cnt_r + 4'd1;
        if (cnt_r == 4'd15) state_s = ENCODE;
        else                state_s = SHIFT;
      end
      ENCODE: begin
        overflow_s = ovf_calc_s;
        blink_on_s = blink_r;
        if (ovf_calc_s) begin
          seg3_s = SEG_DASH;
          seg2_s = SEG_DASH;
          seg1_s = SEG_DASH;
          seg0_s = SEG_DASH;
        end else begin
          seg3_s = (blank_r && z3_s) ? SEG_BLANK : seg_code(digits_s[15:12]);
          seg2_s = (blank_r && z2_s) ? SEG_BLANK : seg_code(digits_s[11:8]);
          seg1_s = (blank_r && z1_s) ? SEG_BLANK : seg_code(digits_s[7:4]);
          seg0_s = seg_code(digits_s[3:0]);
        end
        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath and registered output state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_r <= 19'd0;      pending_r <= 1'b1;
      mode_r <= 1'b0;       blank_r <= 1'b0;      blink_r <= 1'b0;
      bin_r <= 16'd0;       bcd_r <= 20'h0_0000;  cnt_r <= 4'd0;
      seg0_r <= SEG_BLANK;  seg1_r <= SEG_BLANK;
      seg2_r <= SEG_BLANK;  seg3_r <= SEG_BLANK;
      overflow_r <= 1'b0;   busy_r <= 1'b0;       blink_on_r <= 1'b0;
    end else begin
      last_r <= last_s;     pending_r <= pending_s;
      mode_r <= mode_s;     blank_r <= blank_s;   blink_r <= blink_s;
      bin_r <= bin_s;       bcd_r <= bcd_s;       cnt_r <= cnt_s;
      seg0_r <= seg0_s;     seg1_r <= seg1_s;
      seg2_r <= seg2_s;     seg3_r <= seg3_s;
      overflow_r <= overflow_s;
      busy_r <= (state_s != IDLE);
      blink_on_r <= blink_on_s;
    end
  end

  // Free-running blink divider; conversions never touch it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_r   <= {CW{1'b0}};
      phase_r <= 1'b0;
    end else if (div_r == CW'(BLINK_DIV - 1)) begin
      div_r   <= {CW{1'b0}};
      phase_r <= ~phase_r;
    end else begin
      div_r   <= div_r + CW'(1);
      phase_r <= phase_r;
    end
  end

  assign mask_s   = blink_on_r && phase_r;
  assign hex0_n   = mask_s ? SEG_BLANK : seg0_r;
  assign hex1_n   = mask_s ? SEG_BLANK : seg1_r;
  assign hex2_n   = mask_s ? SEG_BLANK : seg2_r;
  assign hex3_n   = mask_s ? SEG_BLANK : seg3_r;
  assign busy     = busy_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_hex_bcd_display_driver.sv
// Directed bench for hex_bcd_display_driver: hand-computed segment patterns,
// busy lengths, overflow, blanking, mid-conversion updates, reset and blink.
module tb_hex_bcd_display_driver;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
  localparam logic [6:0] SB = 7'b0000011, SE = 7'b0000110, SF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111, DS = 7'b0111111;

  localparam logic [27:0] D_ZERO  = {S0, S0, S0, S0};
  localparam logic [27:0] D_BEEF  = {SB, SE, SE, SF};
  localparam logic [27:0] D_1234  = {S1, S2, S3, S4};
  localparam logic [27:0] D_42    = {BL, BL, S4, S2};
  localparam logic [27:0] D_OVF   = {DS, DS, DS, DS};
  localparam logic [27:0] D_5     = {BL, BL, BL, S5};
  localparam logic [27:0] D_5678  = {S5, S6, S7, S8};
  localparam logic [27:0] D_7     = {S0, S0, S0, S7};
  localparam logic [27:0] D_BLANK = {BL, BL, BL, BL};

  logic        clk;
  logic        reset_n;
  logic [31:0] value_in;
  logic [6:0]  hex0_n, hex1_n, hex2_n, hex3_n;
  logic        busy, overflow;
  logic [27:0] disp;

  int n_vec = 0;
  int n_bad = 0;
  int ncyc  = 0;
  int bcnt;

  hex_bcd_display_driver #(.BLINK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .value_in(value_in),
    .hex0_n(hex0_n), .hex1_n(hex1_n), .hex2_n(hex2_n), .hex3_n(hex3_n),
    .busy(busy), .overflow(overflow)
  );

  assign disp = {hex3_n, hex2_n, hex1_n, hex0_n};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge; ncyc mirrors the DUT blink divider (edges since reset release).
  task automatic tick();
    @(posedge clk);
    if (reset_n) ncyc++;
    #1;
  endtask

  // Apply a word and wait for the conversion to finish; returns busy-high cycle count.
  task automatic run_conv(input logic [31:0] v, output int cycles);
    int c;
    c = 0;
    value_in = v;
    tick();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy === 1'b1) c++;
      else if (c > 0) break;
    end
    cycles = c;
  endtask

  initial begin
    reset_n  = 1'b1;
    value_in = 32'h0000_0000;
    #2 reset_n = 1'b0;
    #1;
    check("reset_disp", {4'h0, disp}, {4'h0, D_BLANK});
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ovf", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick(); tick(); tick();
    check("post_reset_zero", {4'h0, disp}, {4'h0, D_ZERO});

    run_conv(32'h0000_BEEF, bcnt);
    check("beef_busy", bcnt, 32'd1);
    check("beef_disp", {4'h0, disp}, {4'h0, D_BEEF});
    check("beef_ovf", {31'd0, overflow}, 32'd0);

    run_conv(32'h0001_04D2, bcnt);
    check("d1234_busy", bcnt, 32'd17);
    check("d1234_disp", {4'h0, disp}, {4'h0, D_1234});
    check("d1234_ovf", {31'd0, overflow}, 32'd0);

    run_conv(32'h0003_002A, bcnt);
    check("d42_busy", bcnt, 32'd17);
    check("d42_disp", {4'h0, disp}, {4'h0, D_42});

    run_conv(32'h0001_3039, bcnt);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_disp", {4'h0, disp}, {4'h0, D_OVF});

    run_conv(32'h0002_0005, bcnt);
    check("hexblank_busy", bcnt, 32'd1);
    check("hexblank_ovf", {31'd0, overflow}, 32'd0);
    check("hexblank_disp", {4'h0, disp}, {4'h0, D_5});

    // Second word arrives mid-SHIFT; first conversion finishes, then one IDLE cycle, then the second.
    value_in = 32'h0001_04D2;
    tick();
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) value_in = 32'h0001_162E;
      tick();
      check($sformatf("mid_busy_%0d", i), {31'd0, busy},
            {31'd0, ((i >= 1 && i <= 17) || (i >= 19 && i <= 35)) ? 1'b1 : 1'b0});
      check($sformatf("mid_disp_%0d", i), {4'h0, disp},
            {4'h0, (i < 18) ? D_5 : ((i < 36) ? D_1234 : D_5678)});
    end

    value_in = 32'h0001_04D2;
    tick(); tick(); tick();
    check("midshift_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    ncyc = 0;
    #1;
    check("rst_mid_disp", {4'h0, disp}, {4'h0, D_BLANK});
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_ovf", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1;
    value_in = 32'h0000_0000;
    reset_n  = 1'b1;
    tick(); tick(); tick();
    check("rst_rel_disp", {4'h0, disp}, {4'h0, D_ZERO});
    check("rst_rel_busy", {31'd0, busy}, 32'd0);

    run_conv(32'h0004_0007, bcnt);
    check("blink_busy", bcnt, 32'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("blink_%0d", i), {4'h0, disp},
            {4'h0, (((ncyc / 4) % 2) == 1) ? D_BLANK : D_7});
      tick();
    end

    run_conv(32'h0000_0007, bcnt);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("noblink_%0d", i), {4'h0, disp}, {4'h0, D_7});
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
